// File: rtl/vmem_rect_fill.sv
// Rectangle-fill engine on the vmem write port; CPU stores pass through with priority.
// Define VMEM_FILL_CLIP_EN to clip fills to the FB_W x FB_H frame buffer.
`timescale 1ns/1ps
module vmem_rect_fill #(
  parameter int FB_W = 240,
  parameter int FB_H = 240
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        reg_we_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [2:0]  cpu_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  if (FB_W < 1 || FB_W > 256 || FB_H < 1 || FB_H > 256) begin : g_fb_range
    $error("vmem_rect_fill: FB_W/FB_H must fit 8-bit coordinates");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [7:0] org_x_q, org_y_q;
  logic [8:0] size_w_q, size_h_q;
  logic [2:0] color_q;
  logic       done_flag_q, abort_flag_q;

  logic [8:0] x_q, y_q, x_last_q, y_last_q;
  logic [7:0] x0_q;
  logic [2:0] fill_color_q;
  logic [8:0] we_eff, he_eff;

  logic ctrl_wr, start_req, abort_req, busy, eng_we, last_px;

  assign ctrl_wr   = reg_we_i && (reg_addr_i[3:2] == 2'd0);
  assign start_req = ctrl_wr && reg_wdata_i[0];
  assign abort_req = ctrl_wr && reg_wdata_i[1];
  assign busy      = (state_q == S_SETUP) || (state_q == S_RUN);
  assign eng_we    = (state_q == S_RUN) && !cpu_we_i;
  assign last_px   = (x_q == x_last_q) && (y_q == y_last_q);

  logic unused_bits;
  assign unused_bits = ^{reg_wdata_i[31:25], reg_wdata_i[15:9], reg_addr_i[1:0]};

`ifdef VMEM_FILL_CLIP_EN
  localparam logic [9:0] FB_W10 = 10'(FB_W);
  localparam logic [9:0] FB_H10 = 10'(FB_H);
  logic [8:0] x_room, y_room;

  always_comb begin
    x_room = 9'(FB_W10 - {2'b00, org_x_q});
    y_room = 9'(FB_H10 - {2'b00, org_y_q});
    we_eff = '0;
    he_eff = '0;
    // Origin outside the frame buffer leaves a zero-area fill.
    if ({2'b00, org_x_q} < FB_W10) we_eff = (size_w_q < x_room) ? size_w_q : x_room;
    if ({2'b00, org_y_q} < FB_H10) he_eff = (size_h_q < y_room) ? size_h_q : y_room;
  end
`else
  assign we_eff = size_w_q;
  assign he_eff = size_h_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_req) state_d = S_SETUP;
      S_SETUP: begin
        if (abort_req)                           state_d = S_IDLE;
        else if (we_eff == '0 || he_eff == '0)   state_d = S_DONE;
        else                                     state_d = S_RUN;
      end
      S_RUN: begin
        if (abort_req)              state_d = S_IDLE;
        else if (eng_we && last_px) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      org_x_q  <= '0;
      org_y_q  <= '0;
      size_w_q <= '0;
      size_h_q <= '0;
      color_q  <= '0;
    end else if (reg_we_i) begin
      case (reg_addr_i[3:2])
        2'd1: begin
          org_x_q <= reg_wdata_i[7:0];
          org_y_q <= reg_wdata_i[23:16];
        end
        2'd2: begin
          size_w_q <= reg_wdata_i[8:0];
          size_h_q <= reg_wdata_i[24:16];
        end
        2'd3:    color_q <= reg_wdata_i[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_flag_q  <= 1'b0;
      abort_flag_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_req) begin
        done_flag_q  <= 1'b0;
        abort_flag_q <= 1'b0;
      end
      if (state_q == S_DONE)  done_flag_q  <= 1'b1;
      if (busy && abort_req)  abort_flag_q <= 1'b1;
    end
  end

  // Working copies are taken in SETUP so register writes only affect the next fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q          <= '0;
      y_q          <= '0;
      x_last_q     <= '0;
      y_last_q     <= '0;
      x0_q         <= '0;
      fill_color_q <= '0;
    end else if (state_q == S_SETUP) begin
      x_q          <= {1'b0, org_x_q};
      y_q          <= {1'b0, org_y_q};
      x0_q         <= org_x_q;
      x_last_q     <= {1'b0, org_x_q} + we_eff - 9'd1;
      y_last_q     <= {1'b0, org_y_q} + he_eff - 9'd1;
      fill_color_q <= color_q;
    end else if (eng_we) begin
      if (x_q == x_last_q) begin
        x_q <= {1'b0, x0_q};
        y_q <= y_q + 9'd1;
      end else begin
        x_q <= x_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rdata_o <= '0;
    end else begin
      case (reg_addr_i[3:2])
        2'd0:    reg_rdata_o <= {29'd0, abort_flag_q, done_flag_q, busy};
        2'd1:    reg_rdata_o <= {8'd0, org_y_q, 8'd0, org_x_q};
        2'd2:    reg_rdata_o <= {7'd0, size_h_q, 7'd0, size_w_q};
        default: reg_rdata_o <= {29'd0, color_q};
      endcase
    end
  end

  always_comb begin
    vmem_we_o    = cpu_we_i | eng_we;
    vmem_addr_o  = '0;
    vmem_wdata_o = '0;
    if (cpu_we_i) begin
      vmem_addr_o  = cpu_addr_i;
      vmem_wdata_o = cpu_wdata_i;
    end else if (eng_we) begin
      vmem_addr_o  = {y_q[7:0], x_q[7:0]};
      vmem_wdata_o = fill_color_q;
    end
  end

  assign busy_o = busy;
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_vmem_rect_fill.sv
// Randomised and directed bench for vmem_rect_fill against a queue-based pixel model.
`timescale 1ns/1ps
module tb_vmem_rect_fill;
  localparam int FB_W = 240;
  localparam int FB_H = 240;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reg_we;
  logic [3:0] reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic cpu_we;
  logic [15:0] cpu_addr;
  logic [2:0] cpu_wdata;
  logic vmem_we;
  logic [15:0] vmem_addr;
  logic [2:0] vmem_wdata;
  logic busy, done;

  vmem_rect_fill #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata),
    .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .vmem_we_o(vmem_we), .vmem_addr_o(vmem_addr), .vmem_wdata_o(vmem_wdata),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit cpu_rand = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a fill is the list of pixels it must write, consumed one per free cycle.
  logic [18:0] m_q[$];
  bit m_setup = 0, m_done_now = 0, m_done_st = 0, m_abort_st = 0;
  bit m_busy_now, m_eng, m_done_next;
  logic [7:0] m_x0 = 0, m_y0 = 0;
  logic [8:0] m_w = 0, m_h = 0;
  logic [2:0] m_col = 0;
  logic [31:0] m_rdata = 0;
  logic [18:0] m_head;
  int m_we_e, m_he_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_setup = 0; m_done_now = 0; m_done_st = 0; m_abort_st = 0;
      m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_col = 0; m_rdata = 0;
      check("rst_vmem_we", {31'd0, vmem_we}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdata", reg_rdata, 32'd0);
    end else begin
      m_busy_now = m_setup || (m_q.size() > 0);
      m_eng = !m_setup && (m_q.size() > 0) && !cpu_we;
      check("busy", {31'd0, busy}, {31'd0, m_busy_now});
      check("done", {31'd0, done}, {31'd0, m_done_now});
      check("vmem_we", {31'd0, vmem_we}, {31'd0, cpu_we | m_eng});
      if (cpu_we) begin
        check("cpu_addr", {16'd0, vmem_addr}, {16'd0, cpu_addr});
        check("cpu_data", {29'd0, vmem_wdata}, {29'd0, cpu_wdata});
      end else if (m_eng) begin
        m_head = m_q[0];
        check("px_addr", {16'd0, vmem_addr}, {16'd0, m_head[18:3]});
        check("px_data", {29'd0, vmem_wdata}, {29'd0, m_head[2:0]});
      end
      check("rdata", reg_rdata, m_rdata);
      case (reg_addr[3:2])
        2'd0:    m_rdata = {29'd0, m_abort_st, m_done_st, m_busy_now};
        2'd1:    m_rdata = {8'd0, m_y0, 8'd0, m_x0};
        2'd2:    m_rdata = {7'd0, m_h, 7'd0, m_w};
        default: m_rdata = {29'd0, m_col};
      endcase
      m_done_next = 0;
      if (m_setup) begin
        m_setup = 0;
        if (m_q.size() == 0) m_done_next = 1;
      end else if (m_eng) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done_next = 1;
      end
      if (m_done_now) m_done_st = 1;
      if (reg_we) begin
        case (reg_addr[3:2])
          2'd0: begin
            if (m_busy_now && reg_wdata[1]) begin
              m_q.delete(); m_setup = 0; m_done_next = 0; m_abort_st = 1;
            end else if (!m_busy_now && !m_done_now && reg_wdata[0]) begin
              m_done_st = 0; m_abort_st = 0; m_setup = 1;
`ifdef VMEM_FILL_CLIP_EN
              m_we_e = (int'(m_x0) >= FB_W) ? 0 : ((int'(m_w) < FB_W - int'(m_x0)) ? int'(m_w) : FB_W - int'(m_x0));
              m_he_e = (int'(m_y0) >= FB_H) ? 0 : ((int'(m_h) < FB_H - int'(m_y0)) ? int'(m_h) : FB_H - int'(m_y0));
`else
              m_we_e = int'(m_w);
              m_he_e = int'(m_h);
`endif
              for (int j = 0; j < m_he_e; j++)
                for (int i = 0; i < m_we_e; i++)
                  m_q.push_back({8'(int'(m_y0) + j), 8'(int'(m_x0) + i), m_col});
            end
          end
          2'd1: begin m_x0 = reg_wdata[7:0]; m_y0 = reg_wdata[23:16]; end
          2'd2: begin m_w = reg_wdata[8:0]; m_h = reg_wdata[24:16]; end
          default: m_col = reg_wdata[2:0];
        endcase
      end
      m_done_now = m_done_next;
    end
  end

  // Write/done log for the directed literal checks.
  int wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [2:0] wr_dat[$];
  int done_cyc[$];
  always @(negedge clk) begin
    if (rst_n && vmem_we) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(vmem_addr); wr_dat.push_back(vmem_wdata);
    end
    if (rst_n && done) done_cyc.push_back(cyc);
  end

  task automatic clr_log();
    wr_cyc.delete(); wr_addr.delete(); wr_dat.delete(); done_cyc.delete();
  endtask

  task automatic step(input bit we, input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_we = we; reg_addr = a; reg_wdata = d;
    cpu_we = cpu_rand && ($urandom_range(0, 3) == 0);
    cpu_addr = 16'($urandom); cpu_wdata = 3'($urandom);
  endtask

  task automatic prog(input logic [7:0] x0, input logic [7:0] y0, input logic [8:0] w,
                      input logic [8:0] h, input logic [2:0] c);
    step(1, 4'h4, {8'd0, y0, 8'd0, x0});
    step(1, 4'h8, {7'd0, h, 7'd0, w});
    step(1, 4'hC, {29'd0, c});
  endtask

  task automatic start(output int n);
    step(1, 4'h0, 32'd1);
    n = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      step(0, 4'h0, 32'd0);
      if (!busy && !done) break;
    end
    if (k >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [31:0] v);
    step(0, a, 32'd0);
    step(0, a, 32'd0);
    v = reg_rdata;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, a, r, k;
    logic [31:0] v;
    logic [3:0] ra;
    logic [31:0] rd;
    logic [15:0] exp_b[6];
    reg_we = 0; reg_addr = 0; reg_wdata = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    #1;
    check("reset_vmem_we", {31'd0, vmem_we}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rdata", reg_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Basic fill
    prog(8'd10, 8'd20, 9'd3, 9'd2, 3'd5);
    clr_log();
    start(n);
    wait_idle(50);
    exp_b = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};
    check("basic_count", wr_cyc.size(), 6);
    for (int i = 0; i < 6 && i < wr_cyc.size(); i++) begin
      check("basic_addr", {16'd0, wr_addr[i]}, {16'd0, exp_b[i]});
      check("basic_cyc", wr_cyc[i], n + 2 + i);
      check("basic_data", {29'd0, wr_dat[i]}, 32'd5);
    end
    check("basic_done_n", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("basic_done_cyc", done_cyc[0], n + 8);
    read_reg(4'h0, v);
    check("basic_status", v, 32'b010);

    // Contention
    prog(8'd50, 8'd60, 9'd4, 9'd1, 3'd3);
    clr_log();
    start(n);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    cpu_we = 1; cpu_addr = 16'h0001; cpu_wdata = 3'd2;
    wait_idle(50);
    check("cont_count", wr_cyc.size(), 5);
    if (wr_cyc.size() == 5) begin
      check("cont_px0", {wr_cyc[0], 16'(wr_addr[0])}, {n + 2, 16'h3C32});
      check("cont_cpu", {wr_cyc[1], 16'(wr_addr[1])}, {n + 3, 16'h0001});
      check("cont_cpu_data", {29'd0, wr_dat[1]}, 32'd2);
      check("cont_px1", {wr_cyc[2], 16'(wr_addr[2])}, {n + 4, 16'h3C33});
      check("cont_px3", {wr_cyc[4], 16'(wr_addr[4])}, {n + 6, 16'h3C35});
    end
    if (done_cyc.size() > 0) check("cont_done_cyc", done_cyc[0], n + 7);
    else check("cont_done_n", 0, 1);

    // Zero size
    prog(8'd5, 8'd5, 9'd0, 9'd7, 3'd1);
    clr_log();
    start(n);
    wait_idle(20);
    check("zero_writes", wr_cyc.size(), 0);
    if (done_cyc.size() > 0) check("zero_done_cyc", done_cyc[0], n + 2);
    else check("zero_done_n", 0, 1);

    // Restart while busy is ignored
    prog(8'd100, 8'd100, 9'd5, 9'd2, 3'd6);
    clr_log();
    start(n);
    step(0, 0, 0); step(0, 0, 0); step(1, 4'h0, 32'd1);
    wait_idle(50);
    check("restart_writes", wr_cyc.size(), 10);
    if (done_cyc.size() == 1) check("restart_done_cyc", done_cyc[0], n + 12);
    else check("restart_done_n", done_cyc.size(), 1);

    // Clipping / wrap at the frame-buffer edge
    prog(8'd238, 8'd239, 9'd5, 9'd3, 3'd4);
    clr_log();
    start(n);
    wait_idle(50);
`ifdef VMEM_FILL_CLIP_EN
    check("clip_count", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) begin
      check("clip_a0", {16'd0, wr_addr[0]}, 32'hEFEE);
      check("clip_a1", {16'd0, wr_addr[1]}, 32'hEFEF);
    end
`else
    check("noclip_count", wr_cyc.size(), 15);
    if (wr_cyc.size() == 15) begin
      check("noclip_first", {16'd0, wr_addr[0]}, 32'hEFEE);
      check("noclip_last", {16'd0, wr_addr[14]}, 32'hF1F2);
    end
`endif

    // Abort after 100 engine writes
    prog(8'd0, 8'd0, 9'd240, 9'd240, 3'd7);
    clr_log();
    start(n);
    for (k = 0; k < 300 && wr_cyc.size() < 100; k++) step(0, 0, 0);
    check("abort_reached_100", {31'd0, wr_cyc.size() >= 100}, 32'd1);
    step(1, 4'h0, 32'd2);
    a = cyc;
    repeat (20) step(0, 0, 0);
    check("abort_no_late_write", {31'd0, wr_cyc[$] <= a + 1}, 32'd1);
    check("abort_no_done", done_cyc.size(), 0);
    read_reg(4'h0, v);
    check("abort_status", v, 32'b100);

    // Asynchronous reset mid-fill
    prog(8'd1, 8'd2, 9'd20, 9'd20, 3'd2);
    start(n);
    repeat (10) step(0, 0, 0);
    check("pre_reset_we", {31'd0, vmem_we}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("async_vmem_we", {31'd0, vmem_we}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    read_reg(4'h0, v);
    check("post_reset_status", v, 32'd0);
    read_reg(4'h4, v);
    check("post_reset_origin", v, 32'd0);

    // Randomised fills with CPU contention and stray register traffic
    cpu_rand = 1;
    for (int t = 0; t < 40; t++) begin
      prog(8'($urandom), 8'($urandom), 9'($urandom_range(0, 7)), 9'($urandom_range(0, 5)), 3'($urandom));
      start(n);
      for (k = 0; k < 400; k++) begin
        r = $urandom_range(0, 29);
        if (r == 0) step(1, 4'h0, {30'd0, 2'($urandom)});
        else if (r == 1) begin
          ra = {2'($urandom_range(1, 3)), 2'b00};
          rd = $urandom;
          if (ra == 4'h8) rd = rd & 32'h0007_0007;
          step(1, ra, rd);
        end else step(0, 4'($urandom), 32'd0);
        if (!busy && !done) break;
      end
      if (k >= 400) begin
        n_cmp++; n_bad++;
        $display("FAIL random_fill: still busy after 400 cycles, required idle");
      end
    end
    cpu_rand = 0;
    wait_idle(500);
    repeat (3) step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
